// File: rtl/raycast_pkg.sv
// Shared types and constants for the ray/wall sequencer.
//   Q88_W    : width of a signed/unsigned Q8.8 value
//   DIST_INF : "no hit yet" distance
//   seq_state_e, wall_t, ray_t : sequencer state encoding and coordinate bundles
package raycast_pkg;

    localparam int unsigned Q88_W = 16;
    localparam logic [Q88_W-1:0] DIST_INF = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StTest  = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [Q88_W-1:0] x3;
        logic [Q88_W-1:0] y3;
        logic [Q88_W-1:0] x4;
        logic [Q88_W-1:0] y4;
    } wall_t;

    typedef struct packed {
        logic [Q88_W-1:0] x1;
        logic [Q88_W-1:0] y1;
        logic [Q88_W-1:0] x2;
        logic [Q88_W-1:0] y2;
    } ray_t;

endpackage

// File: rtl/nearest_hit_cmp.sv
// Combinational accept logic for the nearest-hit search.
//   en         : a wall is under test this cycle
//   isect_hit  : intersection unit reports a valid hit
//   isect_dist : hit distance (unsigned Q8.8)
//   best_dist  : nearest distance accepted so far
//   accept     : replace the current best with this hit
// Optional build macro RAYSEQ_MIN_DIST_EN: hits nearer than MIN_DIST are rejected.
module nearest_hit_cmp
    import raycast_pkg::*;
#(
    parameter logic [Q88_W-1:0] MIN_DIST = 16'h0010
) (
    input  logic             en,
    input  logic             isect_hit,
    input  logic [Q88_W-1:0] isect_dist,
    input  logic [Q88_W-1:0] best_dist,
    output logic             accept
);

    logic closer;

    // Strict compare: on equal distance the earlier (lower-index) wall is kept.
    assign closer = isect_dist < best_dist;

`ifdef RAYSEQ_MIN_DIST_EN
    assign accept = en && isect_hit && closer && (isect_dist >= MIN_DIST);
`else
    logic unused_min_dist;
    assign unused_min_dist = ^MIN_DIST;
    assign accept = en && isect_hit && closer;
`endif

endmodule

// File: rtl/ray_wall_sequencer.sv
// Walks the wall memory for one latched ray, feeds each wall to the external
// intersection unit and keeps the nearest accepted hit, then offers the result
// over a valid/ready handshake.
//   clk, reset          : clock, synchronous active-high reset
//   start, ray_*        : scan request and ray points (latched on accept)
//   busy                : high whenever not idle
//   wall_addr, wall_*   : wall memory address / data (1-cycle read latency)
//   isect_*             : operands to, and results from, the intersection unit
//   result_valid/ready  : result handshake
//   hit, nearest_*      : result of the scan
// Optional build macro RAYSEQ_MIN_DIST_EN enables the near-clip in nearest_hit_cmp.
module ray_wall_sequencer
    import raycast_pkg::*;
#(
    parameter int unsigned      WALL_COUNT  = 16,
    parameter int unsigned      WALL_ADDR_W = 4,
    parameter logic [Q88_W-1:0] MIN_DIST    = 16'h0010
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [Q88_W-1:0]       ray_x1,
    input  logic [Q88_W-1:0]       ray_y1,
    input  logic [Q88_W-1:0]       ray_x2,
    input  logic [Q88_W-1:0]       ray_y2,
    output logic                   busy,
    output logic [WALL_ADDR_W-1:0] wall_addr,
    input  logic [Q88_W-1:0]       wall_x3,
    input  logic [Q88_W-1:0]       wall_y3,
    input  logic [Q88_W-1:0]       wall_x4,
    input  logic [Q88_W-1:0]       wall_y4,
    output logic [Q88_W-1:0]       isect_x1,
    output logic [Q88_W-1:0]       isect_y1,
    output logic [Q88_W-1:0]       isect_x2,
    output logic [Q88_W-1:0]       isect_y2,
    output logic [Q88_W-1:0]       isect_x3,
    output logic [Q88_W-1:0]       isect_y3,
    output logic [Q88_W-1:0]       isect_x4,
    output logic [Q88_W-1:0]       isect_y4,
    input  logic                   isect_hit,
    input  logic [Q88_W-1:0]       isect_dist,
    input  logic [Q88_W-1:0]       isect_uv,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   hit,
    output logic [Q88_W-1:0]       nearest_dist,
    output logic [Q88_W-1:0]       nearest_uv,
    output logic [WALL_ADDR_W-1:0] nearest_wall
);

    localparam logic [WALL_ADDR_W-1:0] LastAddr = WALL_ADDR_W'(WALL_COUNT - 1);

    seq_state_e             state_q, state_d;
    ray_t                   ray_q, ray_d;
    logic [WALL_ADDR_W-1:0] addr_q, addr_d;
    logic [Q88_W-1:0]       best_dist_q, best_dist_d;
    logic [Q88_W-1:0]       uv_q, uv_d;
    logic [WALL_ADDR_W-1:0] best_wall_q, best_wall_d;
    logic                   hit_q, hit_d;
    logic                   accept;
    wall_t                  wall;

    // Wall operands are only driven while a wall is under test, so the
    // intersection unit sees zeros at reset and between tests.
    always_comb begin
        wall = '0;
        if (state_q == StTest) begin
            wall = '{x3: wall_x3, y3: wall_y3, x4: wall_x4, y4: wall_y4};
        end
    end

    nearest_hit_cmp #(
        .MIN_DIST (MIN_DIST)
    ) u_cmp (
        .en         (state_q == StTest),
        .isect_hit  (isect_hit),
        .isect_dist (isect_dist),
        .best_dist  (best_dist_q),
        .accept     (accept)
    );

    always_comb begin
        state_d     = state_q;
        ray_d       = ray_q;
        addr_d      = addr_q;
        best_dist_d = best_dist_q;
        uv_d        = uv_q;
        best_wall_d = best_wall_q;
        hit_d       = hit_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ray_d       = '{x1: ray_x1, y1: ray_y1, x2: ray_x2, y2: ray_y2};
                    addr_d      = '0;
                    best_dist_d = DIST_INF;
                    uv_d        = '0;
                    best_wall_d = '0;
                    hit_d       = 1'b0;
                    state_d     = StFetch;
                end
            end
            StFetch: state_d = StTest;
            StTest: begin
                if (accept) begin
                    best_dist_d = isect_dist;
                    uv_d        = isect_uv;
                    best_wall_d = addr_q;
                    hit_d       = 1'b1;
                end
                if (addr_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + WALL_ADDR_W'(1);
                    state_d = StFetch;
                end
            end
            StDone: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ray_q       <= '0;
            addr_q      <= '0;
            best_dist_q <= DIST_INF;
            uv_q        <= '0;
            best_wall_q <= '0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ray_q       <= ray_d;
            addr_q      <= addr_d;
            best_dist_q <= best_dist_d;
            uv_q        <= uv_d;
            best_wall_q <= best_wall_d;
            hit_q       <= hit_d;
        end
    end

    assign busy         = state_q != StIdle;
    assign result_valid = state_q == StDone;
    assign wall_addr    = addr_q;
    assign hit          = hit_q;
    assign nearest_dist = best_dist_q;
    assign nearest_uv   = uv_q;
    assign nearest_wall = best_wall_q;
    assign isect_x1     = ray_q.x1;
    assign isect_y1     = ray_q.y1;
    assign isect_x2     = ray_q.x2;
    assign isect_y2     = ray_q.y2;
    assign isect_x3     = wall.x3;
    assign isect_y3     = wall.y3;
    assign isect_x4     = wall.x4;
    assign isect_y4     = wall.y4;

endmodule
